// File: rtl/procyon_ccu_ifq_fill.sv
// procyon_ccu_ifq_fill
//
// Cache-line fill engine between the IFQ entry/arbiter and the CCU bus.
// Accepts one pending IFQ fetch, issues a single burst read for the line,
// assembles the returned beats (beat 0 at the LSB) and hands the completed
// line to the I-cache fill port while pulsing o_ccu_done to retire the IFQ
// entry. A bus error terminates the burst and reports done with o_ccu_err
// set and no I-cache write. Only one request is in flight at a time.
//
// Ports:
//   clk, n_rst        clock, synchronous active-low reset
//   i_ifq_valid       IFQ entry holds a pending fetch
//   i_ifq_addr        line address of the pending fetch
//   o_ccu_done        one-cycle pulse retiring the IFQ entry
//   o_ccu_err         qualifies o_ccu_done: fill ended with a bus error
//   o_bus_req         burst read request, held until i_bus_ack
//   o_bus_addr        byte address of the line (offset bits zero)
//   i_bus_ack         bus accepted the request
//   i_bus_data_valid  beat valid
//   i_bus_data        beat data
//   i_bus_err         burst error, terminates the burst
//   o_ic_fill_en      one-cycle I-cache write strobe
//   o_ic_fill_addr    line address for the I-cache write
//   o_ic_fill_data    assembled line for the I-cache write

module procyon_ccu_ifq_fill #(
    parameter int OPTN_ADDR_WIDTH     = 32,
    parameter int OPTN_IC_LINE_SIZE   = 32,
    parameter int OPTN_BUS_DATA_WIDTH = 32,
    localparam int IC_LINE_WIDTH      = OPTN_IC_LINE_SIZE * 8,
    localparam int IC_OFFSET_WIDTH    = $clog2(OPTN_IC_LINE_SIZE),
    localparam int BEATS              = IC_LINE_WIDTH / OPTN_BUS_DATA_WIDTH,
    localparam int BEAT_CNT_WIDTH     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                       clk,
    input  logic                                       n_rst,

    input  logic                                       i_ifq_valid,
    input  logic [OPTN_ADDR_WIDTH-1:IC_OFFSET_WIDTH]   i_ifq_addr,
    output logic                                       o_ccu_done,
    output logic                                       o_ccu_err,

    output logic                                       o_bus_req,
    output logic [OPTN_ADDR_WIDTH-1:0]                 o_bus_addr,
    input  logic                                       i_bus_ack,
    input  logic                                       i_bus_data_valid,
    input  logic [OPTN_BUS_DATA_WIDTH-1:0]             i_bus_data,
    input  logic                                       i_bus_err,

    output logic                                       o_ic_fill_en,
    output logic [OPTN_ADDR_WIDTH-1:IC_OFFSET_WIDTH]   o_ic_fill_addr,
    output logic [IC_LINE_WIDTH-1:0]                   o_ic_fill_data
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DATA = 2'b10,
        FILL = 2'b11
    } state_t;

    state_t                                     state_q;
    state_t                                     state_d;

    logic [OPTN_ADDR_WIDTH-1:IC_OFFSET_WIDTH]   addr_r;
    logic [IC_LINE_WIDTH-1:0]                   line_r;
    logic [BEAT_CNT_WIDTH-1:0]                  beat_cnt;
    logic                                       err_r;

    logic                                       accept;
    logic                                       beat_accept;
    logic                                       beat_last;
    logic                                       data_err;

    // A new fetch is only taken in IDLE; while busy the IFQ inputs are ignored.
    assign accept      = (state_q == IDLE) && i_ifq_valid;

    // An error in the same cycle as a beat wins: the beat is discarded.
    assign data_err    = (state_q == DATA) && i_bus_err;
    assign beat_accept = (state_q == DATA) && i_bus_data_valid && !i_bus_err;
    assign beat_last   = (beat_cnt == BEAT_CNT_WIDTH'(BEATS - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_ifq_valid) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_bus_ack) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (i_bus_err) begin
                    state_d = FILL;
                end else if (i_bus_data_valid && beat_last) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Beat counter and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            beat_cnt <= '0;
            err_r    <= 1'b0;
        end else if (accept) begin
            beat_cnt <= '0;
            err_r    <= 1'b0;
        end else begin
            if (data_err) begin
                err_r <= 1'b1;
            end
            // The exit on the last beat keeps this from wrapping mid-burst.
            if (beat_accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address and line buffers (not reset; only meaningful once filled)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (n_rst && accept) begin
            addr_r <= i_ifq_addr;
        end
        if (n_rst && beat_accept) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (beat_cnt == BEAT_CNT_WIDTH'(k)) begin
                    line_r[k*OPTN_BUS_DATA_WIDTH +: OPTN_BUS_DATA_WIDTH] <= i_bus_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: strobes decode registered state only
    // ------------------------------------------------------------------
    assign o_bus_req      = (state_q == REQ);
    assign o_bus_addr     = {addr_r, IC_OFFSET_WIDTH'(0)};

    assign o_ccu_done     = (state_q == FILL);
    assign o_ccu_err      = (state_q == FILL) && err_r;

    assign o_ic_fill_en   = (state_q == FILL) && !err_r;
    assign o_ic_fill_addr = addr_r;
    assign o_ic_fill_data = line_r;

endmodule

// File: tb/tb_procyon_ccu_ifq_fill.sv
module tb_procyon_ccu_ifq_fill;

    localparam int AW    = 32;
    localparam int LS    = 32;
    localparam int DW    = 32;
    localparam int LW    = LS * 8;
    localparam int OW    = 5;
    localparam int BEATS = LW / DW;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              i_ifq_valid;
    logic [AW-1:OW]    i_ifq_addr;
    logic              o_ccu_done;
    logic              o_ccu_err;
    logic              o_bus_req;
    logic [AW-1:0]     o_bus_addr;
    logic              i_bus_ack;
    logic              i_bus_data_valid;
    logic [DW-1:0]     i_bus_data;
    logic              i_bus_err;
    logic              o_ic_fill_en;
    logic [AW-1:OW]    o_ic_fill_addr;
    logic [LW-1:0]     o_ic_fill_data;

    always #5 clk = ~clk;

    procyon_ccu_ifq_fill #(
        .OPTN_ADDR_WIDTH     (AW),
        .OPTN_IC_LINE_SIZE   (LS),
        .OPTN_BUS_DATA_WIDTH (DW)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_ifq_valid      (i_ifq_valid),
        .i_ifq_addr       (i_ifq_addr),
        .o_ccu_done       (o_ccu_done),
        .o_ccu_err        (o_ccu_err),
        .o_bus_req        (o_bus_req),
        .o_bus_addr       (o_bus_addr),
        .i_bus_ack        (i_bus_ack),
        .i_bus_data_valid (i_bus_data_valid),
        .i_bus_data       (i_bus_data),
        .i_bus_err        (i_bus_err),
        .o_ic_fill_en     (o_ic_fill_en),
        .o_ic_fill_addr   (o_ic_fill_addr),
        .o_ic_fill_data   (o_ic_fill_data)
    );

    typedef struct {
        logic [AW-1:OW] addr;
        logic [LW-1:0]  data;
        logic           err;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_asserts = 0;
    int unsigned n_fail    = 0;
    int unsigned n_done    = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] byte_addr, input logic [LW-1:0] data, input logic err);
        exp_t e;
        e.addr = byte_addr[AW-1:OW];
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    function automatic logic [DW-1:0] beat_val(input logic [DW-1:0] seed, input logic [DW-1:0] step, input int unsigned k);
        return seed + step * DW'(k);
    endfunction

    function automatic logic [LW-1:0] mkline(input logic [DW-1:0] seed, input logic [DW-1:0] step);
        logic [LW-1:0] l;
        l = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            l[k*DW +: DW] = beat_val(seed, step, k);
        end
        return l;
    endfunction

    // One clock; outputs sampled 1 time unit after the edge. Every done
    // pulse is matched against the head of the scoreboard.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (o_ccu_done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("done_with_empty_scoreboard", LW'(o_ccu_done), LW'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_ccu_err", LW'(o_ccu_err), LW'(e.err));
                chk("sb_fill_en", LW'(o_ic_fill_en), LW'(!e.err));
                if (!e.err) begin
                    chk("sb_fill_addr", LW'(o_ic_fill_addr), LW'(e.addr));
                    chk("sb_fill_data", o_ic_fill_data, e.data);
                end
            end
        end
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic v, input logic e);
        i_bus_data       = d;
        i_bus_data_valid = v;
        i_bus_err        = e;
        cyc();
        i_bus_data_valid = 1'b0;
        i_bus_err        = 1'b0;
    endtask

    initial begin
        n_rst            = 1'b0;
        i_ifq_valid      = 1'b1;
        i_ifq_addr       = 27'(32'h0000_1240 >> 5);
        i_bus_ack        = 1'b0;
        i_bus_data_valid = 1'b0;
        i_bus_data       = '0;
        i_bus_err        = 1'b0;

        // ---- reset held 2 cycles with a pending request
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_bus_req", LW'(o_bus_req), LW'(0));
            chk("rst_done", LW'(o_ccu_done), LW'(0));
            chk("rst_fill_en", LW'(o_ic_fill_en), LW'(0));
            chk("rst_err", LW'(o_ccu_err), LW'(0));
        end
        n_rst = 1'b1;

        // ---- basic fill, ack two cycles after req rises
        push_exp(32'h0000_1240, mkline(32'h1111_1111, 32'h1111_1111), 1'b0);
        cyc();
        chk("req_after_release", LW'(o_bus_req), LW'(1));
        chk("basic_bus_addr", LW'(o_bus_addr), LW'(32'h0000_1240));
        cyc();
        chk("basic_req_hold1", LW'(o_bus_req), LW'(1));
        cyc();
        chk("basic_req_hold2", LW'(o_bus_req), LW'(1));
        chk("basic_bus_addr_stable", LW'(o_bus_addr), LW'(32'h0000_1240));
        i_bus_ack = 1'b1;
        cyc();
        i_bus_ack = 1'b0;
        chk("basic_req_drop", LW'(o_bus_req), LW'(0));
        for (int unsigned k = 0; k < BEATS; k++) begin
            beat(beat_val(32'h1111_1111, 32'h1111_1111, k), 1'b1, 1'b0);
            chk("basic_done_timing", LW'(o_ccu_done), LW'(k == BEATS - 1));
        end
        i_ifq_valid = 1'b0;
        cyc();
        chk("basic_done_one_cycle", LW'(o_ccu_done), LW'(0));
        chk("basic_fill_en_one_cycle", LW'(o_ic_fill_en), LW'(0));
        chk("basic_done_count", LW'(n_done), LW'(1));

        // ---- gapped beats, garbage on the bus during gaps
        push_exp(32'h0000_1240, mkline(32'h1111_1111, 32'h1111_1111), 1'b0);
        i_ifq_valid = 1'b1;
        i_ifq_addr  = 27'(32'h0000_1240 >> 5);
        cyc();
        chk("gap_req", LW'(o_bus_req), LW'(1));
        i_bus_ack = 1'b1;
        cyc();
        i_bus_ack = 1'b0;
        for (int unsigned i = 0; i < 2 * BEATS - 1; i++) begin
            if (i % 2 == 0) beat(beat_val(32'h1111_1111, 32'h1111_1111, i / 2), 1'b1, 1'b0);
            else            beat(32'hDEAD_BEEF, 1'b0, 1'b0);
            chk("gap_done_timing", LW'(o_ccu_done), LW'(i == 2 * BEATS - 2));
        end
        i_ifq_valid = 1'b0;
        cyc();
        chk("gap_done_count", LW'(n_done), LW'(2));

        // ---- error on beat 3; err/valid during REQ are ignored
        push_exp(32'h0000_3000, '0, 1'b1);
        i_ifq_valid = 1'b1;
        i_ifq_addr  = 27'(32'h0000_3000 >> 5);
        cyc();
        i_bus_ack        = 1'b1;
        i_bus_err        = 1'b1;
        i_bus_data_valid = 1'b1;
        cyc();
        i_bus_ack        = 1'b0;
        i_bus_err        = 1'b0;
        i_bus_data_valid = 1'b0;
        chk("err_req_ignored_err", LW'(o_ccu_done), LW'(0));
        for (int unsigned k = 0; k < 3; k++) begin
            beat(beat_val(32'h5555_0000, 32'h1, k), 1'b1, 1'b0);
            chk("err_no_early_done", LW'(o_ccu_done), LW'(0));
        end
        beat(32'h5555_0003, 1'b1, 1'b1);
        chk("err_done", LW'(o_ccu_done), LW'(1));
        chk("err_flag", LW'(o_ccu_err), LW'(1));
        chk("err_no_fill", LW'(o_ic_fill_en), LW'(0));
        i_ifq_valid = 1'b0;
        cyc();
        chk("err_idle_done", LW'(o_ccu_done), LW'(0));
        chk("err_idle_req", LW'(o_bus_req), LW'(0));

        // ---- back-to-back: second request allocated in the IDLE after done
        push_exp(32'h0000_1000, mkline(32'hA000_0000, 32'h0000_0101), 1'b0);
        i_ifq_valid = 1'b1;
        i_ifq_addr  = 27'(32'h0000_1000 >> 5);
        cyc();
        i_bus_ack = 1'b1;
        cyc();
        i_bus_ack = 1'b0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            beat(beat_val(32'hA000_0000, 32'h0000_0101, k), 1'b1, 1'b0);
        end
        chk("b2b_first_done", LW'(o_ccu_done), LW'(1));
        i_ifq_valid = 1'b0;
        cyc();
        chk("b2b_idle_req", LW'(o_bus_req), LW'(0));
        push_exp(32'h0000_2000, mkline(32'hB000_0000, 32'h0001_0001), 1'b0);
        i_ifq_valid = 1'b1;
        i_ifq_addr  = 27'(32'h0000_2000 >> 5);
        cyc();
        chk("b2b_second_req", LW'(o_bus_req), LW'(1));
        chk("b2b_second_addr", LW'(o_bus_addr), LW'(32'h0000_2000));
        i_bus_ack = 1'b1;
        cyc();
        i_bus_ack = 1'b0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            beat(beat_val(32'hB000_0000, 32'h0001_0001, k), 1'b1, 1'b0);
        end
        chk("b2b_second_done", LW'(o_ccu_done), LW'(1));
        i_ifq_valid = 1'b0;
        cyc();
        chk("b2b_done_count", LW'(n_done), LW'(5));

        // ---- reset in the middle of DATA after beat 4
        i_ifq_valid = 1'b1;
        i_ifq_addr  = 27'(32'h0000_4000 >> 5);
        cyc();
        i_bus_ack = 1'b1;
        cyc();
        i_bus_ack = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            beat(beat_val(32'hDEAD_0000, 32'h1, k), 1'b1, 1'b0);
        end
        i_ifq_valid = 1'b0;
        n_rst       = 1'b0;
        cyc();
        chk("mid_rst_req", LW'(o_bus_req), LW'(0));
        chk("mid_rst_done", LW'(o_ccu_done), LW'(0));
        chk("mid_rst_fill_en", LW'(o_ic_fill_en), LW'(0));
        n_rst = 1'b1;
        cyc();
        cyc();
        chk("post_rst_idle_req", LW'(o_bus_req), LW'(0));
        chk("post_rst_no_done", LW'(n_done), LW'(5));

        push_exp(32'h0000_5000, mkline(32'hC0C0_0000, 32'h0000_1111), 1'b0);
        i_ifq_valid = 1'b1;
        i_ifq_addr  = 27'(32'h0000_5000 >> 5);
        cyc();
        chk("post_rst_req", LW'(o_bus_req), LW'(1));
        chk("post_rst_addr", LW'(o_bus_addr), LW'(32'h0000_5000));
        i_bus_ack = 1'b1;
        cyc();
        i_bus_ack = 1'b0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            beat(beat_val(32'hC0C0_0000, 32'h0000_1111, k), 1'b1, 1'b0);
            chk("post_rst_done_timing", LW'(o_ccu_done), LW'(k == BEATS - 1));
        end
        i_ifq_valid = 1'b0;
        cyc();
        cyc();
        chk("final_done_count", LW'(n_done), LW'(6));
        chk("final_scoreboard_empty", LW'(sb.size()), LW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/procyon_ccu_ifq_fill.md
# procyon_ccu_ifq_fill

Cache-line fill engine on the CCU side of the instruction fetch queue (IFQ). It accepts one pending IFQ request (valid + line address), issues a single burst read on the CCU bus, and assembles the returned beats into a full cache line. It then delivers the line to the I-cache fill port and pulses `o_ccu_done`, which retires the IFQ entry. It handles one request at a time and sits between the IFQ entry/arbiter and the bus interface.

## Interface
Parameters:
- `OPTN_ADDR_WIDTH`, 32, physical address width
- `OPTN_IC_LINE_SIZE`, 32, I-cache line size in bytes
- `OPTN_BUS_DATA_WIDTH`, 32, bus beat width in bits; must divide `IC_LINE_WIDTH`
- `IC_LINE_WIDTH`, `OPTN_IC_LINE_SIZE*8`, derived
- `IC_OFFSET_WIDTH`, `$clog2(OPTN_IC_LINE_SIZE)`, derived
- `BEATS`, `IC_LINE_WIDTH/OPTN_BUS_DATA_WIDTH`, derived; 8 at defaults
- `BEAT_CNT_WIDTH`, `max(1,$clog2(BEATS))`, derived

Ports:
- `clk` in 1: clock
- `n_rst` in 1: reset; synchronous, active-low
- `i_ifq_valid` in 1: IFQ entry holds a pending fetch
- `i_ifq_addr` in `[OPTN_ADDR_WIDTH-1:IC_OFFSET_WIDTH]`: line address of the pending fetch
- `o_ccu_done` out 1: one-cycle pulse that retires the IFQ entry
- `o_ccu_err` out 1: qualifies `o_ccu_done`; the fill terminated with a bus error
- `o_bus_req` out 1: burst read request
- `o_bus_addr` out `OPTN_ADDR_WIDTH`: `{addr_r, IC_OFFSET_WIDTH'b0}`
- `i_bus_ack` in 1: bus accepted the request
- `i_bus_data_valid` in 1: beat valid
- `i_bus_data` in `OPTN_BUS_DATA_WIDTH`: beat data
- `i_bus_err` in 1: burst error; it terminates the burst
- `o_ic_fill_en` out 1: one-cycle write strobe to the I-cache
- `o_ic_fill_addr` out `[OPTN_ADDR_WIDTH-1:IC_OFFSET_WIDTH]`: line address
- `o_ic_fill_data` out `IC_LINE_WIDTH`: assembled line

## Operation
- FSM states: IDLE, REQ, DATA, FILL. State is held in a register with synchronous reset to IDLE.
- **IDLE:**
  - If `i_ifq_valid`, latch `i_ifq_addr` into `addr_r`, clear the beat counter and `err_r`, and go to REQ.
  - Otherwise stay in IDLE.
- **REQ:**
  - `o_bus_req`=1, with `o_bus_addr` held stable.
  - On `i_bus_ack`, go to DATA.
  - `i_bus_data_valid` and `i_bus_err` are ignored in REQ.
- **DATA:**
  - On `i_bus_data_valid`, write beat k into `line_r[k*OPTN_BUS_DATA_WIDTH +: OPTN_BUS_DATA_WIDTH]`, where k is the beat counter. Beat 0 lands at the LSB, and the counter increments.
  - If the counter equals `BEATS-1` and a beat is accepted, go to FILL.
  - On `i_bus_err` (with or without `i_bus_data_valid`), set `err_r` and go to FILL immediately. Any beat presented in the same cycle is discarded.
  - Gaps between beats (`i_bus_data_valid`=0) are allowed and hold all state.
- **FILL** (exactly one cycle), then IDLE:
  - `o_ccu_done`=1
  - `o_ccu_err`=`err_r`
  - `o_ic_fill_en`=`~err_r`
- `o_ic_fill_addr`=`addr_r` and `o_ic_fill_data`=`line_r` at all times. They are meaningful only while `o_ic_fill_en`=1.
- Beat counter arithmetic is `BEAT_CNT_WIDTH` bits unsigned. It never wraps within a burst because of the `BEATS-1` exit.
- Only one request is outstanding. While not in IDLE, `i_ifq_valid`/`i_ifq_addr` are ignored.

## Timing
- Reset values:
  - `o_ccu_done`, `o_ccu_err`, `o_bus_req`, `o_ic_fill_en` = 0; state = IDLE.
  - `o_bus_addr` and `o_ic_fill_addr` are undefined until the first acceptance.
  - `o_ic_fill_data` is undefined; `line_r` and `addr_r` are not reset.
- Sequence: request seen in IDLE in cycle 0; `o_bus_req` high from cycle 1 through the ack cycle. With ack in cycle a, beats are accepted from cycle a+1. With the last beat in cycle m, FILL occurs in cycle m+1 and IDLE in cycle m+2.
- Minimum latency, request to done: 1 (REQ) + 1 (ack in the same cycle) + `BEATS` + 1 = 11 cycles at defaults for a gap-free burst.
- Done/valid interaction: the IFQ entry samples `o_ccu_done` in FILL and invalidates at the same edge that returns this block to IDLE. `i_ifq_valid` seen in the following IDLE cycle is therefore a new allocation and is accepted with no duplicate fill.
- Registered outputs: `o_bus_req`, `o_ccu_done` and `o_ic_fill_en` depend on registered state only, with no combinational input-to-output paths.
- Reset mid-operation: the next cycle is IDLE with all strobes 0. No `o_ccu_done` is issued for the aborted request. The bus is expected to be reset in the same cycle.

## Test plan
- **Reset:** hold `n_rst`=0 for 2 cycles with `i_ifq_valid`=1 -> `o_bus_req`, `o_ccu_done`, `o_ic_fill_en`, `o_ccu_err` all 0; `o_bus_req` rises exactly 1 cycle after release.
- **Basic fill:** stimulus:
  - `i_ifq_addr` = 0x0000_1240>>5; ack 2 cycles after `o_bus_req` rises.
  - 8 contiguous beats 0x11111111·(k+1).
  - Required response:
    - `o_bus_addr`=0x0000_1240.
    - `o_ic_fill_data`=0x88888888_..._22222222_11111111.
    - `o_ic_fill_en` and `o_ccu_done` each high for exactly 1 cycle, 1 cycle after beat 7; `o_ccu_err`=0.
- **Gapped beats:** same request with `i_bus_data_valid` alternating 1/0 -> identical line; done only after the 8th valid beat (16 cycles after ack).
- **Error:** `i_bus_err` with beat 3 -> next cycle `o_ccu_done`=1, `o_ccu_err`=1, `o_ic_fill_en`=0; block in IDLE the cycle after.
- **Back-to-back:** second request (addr 0x2000>>5) allocated the cycle after done -> `o_bus_req` 1 cycle later with `o_bus_addr`=0x0000_2000; exactly one done per request; the second line is not corrupted by the first.
- **Reset mid-DATA:** assert `n_rst`=0 after beat 4 -> no done, `o_bus_req`=0; a new request then fills correctly starting from beat 0.
